// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer: steers one source word into one of four holding registers.
// Latency: one cycle from accept to out_valid/out_data on the target channel.
// Backpressure: in_ready drops only while the target channel is full and its consumer is stalled.
module demux_1to4_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             auto_mode,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       rr_ptr,
    output logic [7:0]       xfer_count
);

    logic [WIDTH-1:0] data_q [4];
    logic [3:0]       valid_q;
    logic [1:0]       rr_q;
    logic [7:0]       count_q;

    logic [1:0]       target;
    logic             accept;
    logic [3:0]       load;

    // Ready is a function of held state and out_ready only, never of in_valid/in_data.
    always_comb begin
        target   = auto_mode ? rr_q : in_sel;
        in_ready = !valid_q[target] || out_ready[target];
        accept   = in_valid && in_ready;
        load     = 4'b0000;
        if (accept) begin
            load[target] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= 4'b0000;
            rr_q    <= 2'd0;
            count_q <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    data_q[i] <= in_data;
                end
            end
            // A load wins over a same-cycle drain, sustaining one word per cycle per channel.
            valid_q <= (valid_q & ~out_ready) | load;
            if (accept) begin
                count_q <= count_q + 8'd1;
                if (auto_mode) begin
                    rr_q <= rr_q + 2'd1;
                end
            end
        end
    end

    assign out_data0  = data_q[0];
    assign out_data1  = data_q[1];
    assign out_data2  = data_q[2];
    assign out_data3  = data_q[3];
    assign out_valid  = valid_q;
    assign rr_ptr     = rr_q;
    assign xfer_count = count_q;

endmodule

// File: doc/demux_1to4_reg.md
Name: demux_1to4_reg

Overview:
Registered 1-to-4 demultiplexer with valid/ready handshakes on every channel. It is the distributing counterpart of the 4-to-1 selection mux: it steers one WIDTH-bit source word to one of four destination holding registers in the 16-bit CPU datapath. The target is chosen either by an explicit select or by an internal round-robin pointer. It also keeps a running count of accepted transfers.

Parameters:
WIDTH, 16, data width of the input word and of each output register

Ports:
Clock  input  1  system clock, rising-edge active
Reset  input  1  asynchronous, active-high reset
in_data  input  WIDTH  source word
in_sel  input  2  explicit target channel (used when auto_mode=0)
in_valid  input  1  source word is present
in_ready  output  1  block accepts the word this cycle
auto_mode  input  1  1 = target is rr_ptr; 0 = target is in_sel
out_data0  output  WIDTH  channel 0 holding register
out_data1  output  WIDTH  channel 1 holding register
out_data2  output  WIDTH  channel 2 holding register
out_data3  output  WIDTH  channel 3 holding register
out_valid  output  4  bit i = channel i holds an undelivered word
out_ready  input  4  bit i = channel i consumer takes the word this cycle
rr_ptr  output  2  round-robin target pointer
xfer_count  output  8  number of accepted transfers, modulo 256

Behaviour:
- One clock domain. Reset is asynchronous and active-high; the block reacts immediately, without waiting for a clock edge.
- Reset values:
  - out_data0..3 = 0
  - out_valid = 4'b0000
  - rr_ptr = 0
  - xfer_count = 0
  - Any word held when Reset asserts mid-operation is discarded.
- Target channel: t = auto_mode ? rr_ptr : in_sel (combinational).
- in_ready = !out_valid[t] | out_ready[t] (combinational).
  - Depends only on registered state plus out_ready; no path from in_valid or in_data.
- Accept event: in_valid & in_ready at a rising edge. On that edge:
  - out_data_t <= in_data
  - out_valid[t] <= 1
  - xfer_count <= xfer_count + 1, wrapping 255 -> 0
  - if auto_mode=1: rr_ptr <= rr_ptr + 1, wrapping 3 -> 0; if auto_mode=0, rr_ptr is unchanged
- Latency: a word accepted at edge N is visible on out_data_t with out_valid[t]=1 immediately after edge N. This is one-cycle latency.
- Drain: if out_valid[i] & out_ready[i] and no accept targets channel i on the same edge, then out_valid[i] <= 0. out_data_i keeps its last value after draining.
- Simultaneous drain and accept on the same channel: out_valid[i] stays 1 and out_data_i takes the new word. This sustains one word per cycle per channel.
- Back-pressure:
  - While out_valid[i]=1 and out_ready[i]=0, out_data_i is stable.
  - A word targeting channel i is refused (in_ready=0); xfer_count and rr_ptr do not change.
  - Other channels drain independently.
- in_valid with in_ready=0 has no effect. in_data and in_sel may change freely while not accepted.
- Exactly one channel is loaded per accept; untargeted channels are never written.
- Toggling auto_mode does not reset rr_ptr. The pointer resumes from its held value.
- out_ready[i] while out_valid[i]=0 is ignored.

Test Plan:
1. Reset, then in_sel=00, in_data=16'h0001, in_valid=1 for one cycle, out_ready=0000 -> next cycle: out_valid=0001, out_data0=0001, out_data1..3=0000, xfer_count=1, rr_ptr=0.
2. Back-pressure: with channel 0 full and out_ready[0]=0, drive in_sel=00, data 16'h0002 -> in_ready=0 and out_data0 stays 0001. Then raise out_ready[0]=1 -> in_ready=1; next cycle out_data0=0002, out_valid[0]=1, xfer_count=2.
3. One-hot sweep with out_ready=1111: in_sel=00,01,10,11 with data 000A,000B,000C,000D on consecutive cycles -> out_valid shows 0001,0010,0100,1000 on successive cycles, each paired channel shows its matching data, xfer_count=4.
4. auto_mode=1 from reset, out_ready=1111, six consecutive transfers 0x10..0x15 with in_sel held at 11 -> targets are channels 0,1,2,3,0,1 (out_data0=0x14, out_data1=0x15, out_data2=0x12, out_data3=0x13), and rr_ptr=2 afterwards.
5. 256 accepts with out_ready=1111 -> xfer_count returns to 0. Separately, 4 accepts in auto mode -> rr_ptr wraps 3 -> 0.
6. With out_valid=0101 and data held, assert Reset between clock edges -> out_valid=0000, all out_data=0, rr_ptr=0 and xfer_count=0 before the next edge. After deassertion, the first accept behaves as in test 1.
